// File: rtl/frogger_game_if.sv
// frogger_game_if: frame-rate control and status bundle between the game sequencer and its environment
interface frogger_game_if;
  logic        start;
  logic        frog_dead;
  logic        frog_win;
  logic [1:0]  home_slot;
  logic        frog_reset;
  logic [2:0]  game_state;
  logic [1:0]  lives;
  logic [3:0]  level;
  logic [13:0] score;
  logic [2:0]  home_filled;
  logic [2:0]  speed_scale;
  logic [5:0]  time_left;
  modport master (
    output start, frog_dead, frog_win, home_slot,
    input  frog_reset, game_state, lives, level, score, home_filled, speed_scale, time_left
  );
  modport slave (
    input  start, frog_dead, frog_win, home_slot,
    output frog_reset, game_state, lives, level, score, home_filled, speed_scale, time_left
  );
endinterface

// File: rtl/frogger_game_ctrl.sv
// frogger_game_ctrl: per-frame game sequencer owning lives, level, score and home slots; define ROUND_TIMER_EN to add the round timer
module frogger_game_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int RESPAWN_FRAMES  = 30,
  parameter int GAMEOVER_FRAMES = 120,
  parameter int SCORE_HOME      = 50,
  parameter int SCORE_LEVEL     = 200,
  parameter int SCORE_MAX       = 9999,
  parameter int TIME_INIT       = 30,
  parameter int TICK_FRAMES     = 60
) (
  input logic frame_clk,
  input logic Reset,
  frogger_game_if.slave bus
);
  typedef enum logic [2:0] {ATTRACT, RESPAWN, PLAY, LEVELUP, GAMEOVER} state_t;
  localparam logic [15:0] R_LAST = 16'(RESPAWN_FRAMES - 1);
  localparam logic [15:0] G_LAST = 16'(GAMEOVER_FRAMES - 1);
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  lives, lives_n;
  logic [3:0]  level, level_n;
  logic [13:0] score, score_n;
  logic [2:0]  home, home_n, slot_bit, speed;
  logic [5:0]  time_left;
  logic [14:0] add, sum;
  logic        timeout, bad, clr;
  assign slot_bit = 3'b001 << bus.home_slot;
  assign bad = bus.frog_dead || timeout || (bus.frog_win && (bus.home_slot == 2'd3 || |(slot_bit & home)));
  // next-state, lives, level, home slots and saturating score for this frame
  always_comb begin
    state_n = state;
    lives_n = lives;
    level_n = level;
    home_n  = home;
    add     = 15'd0;
    clr     = 1'b0;
    case (state)
      ATTRACT: if (bus.start) begin
        state_n = RESPAWN;
        lives_n = 2'(LIVES_INIT);
        level_n = 4'd1;
        home_n  = 3'd0;
        clr     = 1'b1;
      end
      RESPAWN: state_n = cnt == R_LAST ? PLAY : RESPAWN;
      PLAY: if (bad) begin
        lives_n = lives - 2'd1;
        state_n = lives == 2'd1 ? GAMEOVER : RESPAWN;
      end else if (bus.frog_win) begin
        home_n  = home | slot_bit;
        add     = 15'(SCORE_HOME);
        state_n = (home | slot_bit) == 3'b111 ? LEVELUP : RESPAWN;
      end
      LEVELUP: begin
        add     = 15'(SCORE_LEVEL);
        level_n = level == 4'd15 ? level : level + 4'd1;
        home_n  = 3'd0;
        state_n = RESPAWN;
      end
      GAMEOVER: state_n = cnt == G_LAST ? ATTRACT : GAMEOVER;
      default: state_n = ATTRACT;
    endcase
    sum     = {1'b0, score} + add;
    score_n = clr ? 14'd0 : sum > 15'(SCORE_MAX) ? 14'(SCORE_MAX) : sum[13:0];
    cnt_n   = state_n != state ? 16'd0 : cnt + 16'd1;
  end
  // game state registers; the frame counter restarts on every state change
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= ATTRACT;
      cnt   <= 16'd0;
      lives <= 2'd0;
      level <= 4'd1;
      score <= 14'd0;
      home  <= 3'd0;
      speed <= 3'd1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lives <= lives_n;
      level <= level_n;
      score <= score_n;
      home  <= home_n;
      speed <= level_n > 4'd7 ? 3'd7 : level_n[2:0];
    end
  end
`ifdef ROUND_TIMER_EN
  localparam logic [5:0] P_LAST = 6'(TICK_FRAMES - 1);
  logic [5:0] pre, pre_n, time_n;
  assign timeout = time_left == 6'd0;
  // prescaler runs only in PLAY; every RESPAWN entry reloads the round time
  always_comb begin
    pre_n  = pre;
    time_n = time_left;
    if (state == PLAY) begin
      pre_n  = pre == P_LAST ? 6'd0 : pre + 6'd1;
      time_n = pre == P_LAST && time_left != 6'd0 ? time_left - 6'd1 : time_left;
    end
    if (state_n == RESPAWN && state != RESPAWN) begin
      pre_n  = 6'd0;
      time_n = 6'(TIME_INIT);
    end
  end
  // round timer registers
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pre       <= 6'd0;
      time_left <= 6'd0;
    end else begin
      pre       <= pre_n;
      time_left <= time_n;
    end
  end
`else
  logic unused_timer;
  assign unused_timer = ^{TIME_INIT[0], TICK_FRAMES[0]};
  assign timeout      = 1'b0;
  assign time_left    = 6'd0;
`endif
  assign bus.frog_reset  = state == RESPAWN && cnt == 16'd0;
  assign bus.game_state  = state;
  assign bus.lives       = lives;
  assign bus.level       = level;
  assign bus.score       = score;
  assign bus.home_filled = home;
  assign bus.speed_scale = speed;
  assign bus.time_left   = time_left;
endmodule

// File: tb/tb_frogger_game_ctrl.sv
// tb_frogger_game_ctrl: directed and randomized frames checked against a rule-level game model
module tb_frogger_game_ctrl;
  localparam int LI = 3, RESP = 30, GO = 120, SH = 50, SL = 200, SMAX = 9999, TI = 2, TF = 4;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  int tests = 0, fails = 0;
  int m_st, m_left, m_lives, m_level, m_score, m_home, m_time, m_sub;
  frogger_game_if bus();
  frogger_game_ctrl #(
    .LIVES_INIT(LI), .RESPAWN_FRAMES(RESP), .GAMEOVER_FRAMES(GO), .SCORE_HOME(SH),
    .SCORE_LEVEL(SL), .SCORE_MAX(SMAX), .TIME_INIT(TI), .TICK_FRAMES(TF)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );
  always #5 frame_clk = ~frame_clk;
  task automatic check(string tag, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sat(int v);
    return v > SMAX ? SMAX : v;
  endfunction
  task automatic model_reset();
    m_st = 0; m_left = 0; m_lives = 0; m_level = 1; m_score = 0; m_home = 0; m_time = 0; m_sub = 0;
  endtask
  task automatic enter_respawn();
    m_st = 1;
    m_left = RESP;
    m_sub = 0;
`ifdef ROUND_TIMER_EN
    m_time = TI;
`endif
  endtask
  task automatic model_step();
    int slot;
    bit timeout, loss;
    slot = int'(bus.home_slot);
    case (m_st)
      0: if (bus.start) begin
        m_lives = LI; m_level = 1; m_score = 0; m_home = 0;
        enter_respawn();
      end
      1: begin
        m_left--;
        if (m_left == 0) m_st = 2;
      end
      2: begin
        timeout = 1'b0;
`ifdef ROUND_TIMER_EN
        timeout = m_time == 0;
        m_sub++;
        if (m_sub == TF) begin
          m_sub = 0;
          if (m_time > 0) m_time--;
        end
`endif
        loss = bus.frog_dead || timeout || (bus.frog_win && (slot == 3 || m_home[slot]));
        if (loss) begin
          if (m_lives == 1) begin
            m_lives = 0; m_st = 4; m_left = GO;
          end else begin
            m_lives--;
            enter_respawn();
          end
        end else if (bus.frog_win) begin
          m_home |= 1 << slot;
          m_score = sat(m_score + SH);
          if (m_home == 7) m_st = 3;
          else enter_respawn();
        end
      end
      3: begin
        m_score = sat(m_score + SL);
        m_level = m_level < 15 ? m_level + 1 : 15;
        m_home = 0;
        enter_respawn();
      end
      default: begin
        m_left--;
        if (m_left == 0) m_st = 0;
      end
    endcase
  endtask
  task automatic compare_all();
    check("game_state", bus.game_state, m_st);
    check("frog_reset", bus.frog_reset, (m_st == 1 && m_left == RESP) ? 1 : 0);
    check("lives", bus.lives, m_lives);
    check("level", bus.level, m_level);
    check("score", bus.score, m_score);
    check("home_filled", bus.home_filled, m_home);
    check("speed_scale", bus.speed_scale, m_level > 7 ? 7 : m_level);
    check("time_left", bus.time_left, m_time);
  endtask
  task automatic frame(bit s, bit d, bit w, int sl);
    bus.start = s; bus.frog_dead = d; bus.frog_win = w; bus.home_slot = 2'(sl);
    @(posedge frame_clk);
    model_step();
    #1;
    compare_all();
  endtask
  task automatic wait_play();
    for (int i = 0; i < 400 && m_st != 2; i++) frame(0, 0, 0, 0);
    check("reach_play", bus.game_state, 2);
  endtask
  task automatic async_reset();
    #2 Reset = 1'b1;
    #1 model_reset();
    compare_all();
    Reset = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.frog_dead = 0; bus.frog_win = 0; bus.home_slot = 0;
    model_reset();
    #12;
    compare_all();
    check("rst_state", bus.game_state, 0);
    Reset = 1'b0;
    frame(1, 0, 0, 0);
    check("start_respawn", bus.game_state, 1);
    check("start_pulse", bus.frog_reset, 1);
    check("start_lives", bus.lives, 3);
    frame(0, 0, 0, 0);
    check("pulse_one_frame", bus.frog_reset, 0);
    repeat (RESP - 2) frame(0, 0, 0, 0);
    check("still_respawn", bus.game_state, 1);
    frame(0, 0, 0, 0);
    check("play_after_30", bus.game_state, 2);
    frame(0, 0, 1, 0);
    check("win0_score", bus.score, 50);
    wait_play();
    frame(0, 0, 1, 1);
    check("win1_score", bus.score, 100);
    wait_play();
    frame(0, 0, 1, 2);
    check("levelup_state", bus.game_state, 3);
    frame(0, 0, 0, 0);
    check("lvl_score", bus.score, 350);
    check("lvl_level", bus.level, 2);
    check("lvl_home", bus.home_filled, 0);
    check("lvl_speed", bus.speed_scale, 2);
    wait_play();
    frame(0, 0, 1, 1);
    wait_play();
    frame(0, 0, 1, 1);
    check("dup_lives", bus.lives, 2);
    check("dup_score", bus.score, 400);
    wait_play();
    frame(0, 0, 1, 3);
    check("slot3_lives", bus.lives, 1);
    check("slot3_score", bus.score, 400);
    wait_play();
    frame(0, 1, 0, 0);
    check("go_state", bus.game_state, 4);
    check("go_lives", bus.lives, 0);
    repeat (GO - 1) frame(1, 0, 0, 0);
    check("go_hold", bus.game_state, 4);
    frame(0, 0, 0, 0);
    check("go_attract", bus.game_state, 0);
    check("go_score_kept", bus.score, 400);
    frame(1, 0, 0, 0);
    wait_play();
    frame(0, 0, 1, 0);
    wait_play();
    frame(0, 1, 1, 1);
    check("both_home", bus.home_filled, 1);
    check("both_lives", bus.lives, 2);
    wait_play();
    frame(1, 0, 0, 0);
    frame(0, 1, 0, 0);
    repeat (5) frame(0, 0, 0, 0);
    async_reset();
    check("mid_rst_state", bus.game_state, 0);
    check("mid_rst_score", bus.score, 0);
`ifdef ROUND_TIMER_EN
    frame(1, 0, 0, 0);
    wait_play();
    check("t_init", bus.time_left, 2);
    repeat (TF) frame(0, 0, 0, 0);
    check("t_tick1", bus.time_left, 1);
    repeat (TF) frame(0, 0, 0, 0);
    check("t_tick0", bus.time_left, 0);
    check("t_still_play", bus.game_state, 2);
    frame(0, 0, 0, 0);
    check("t_timeout", bus.game_state, 1);
    check("t_lives", bus.lives, 2);
    check("t_reload", bus.time_left, 2);
`endif
    for (int i = 0; i < 3000; i++)
      frame($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3));
    async_reset();
    frame(1, 0, 0, 0);
    for (int l = 0; l < 30; l++) begin
      for (int s = 0; s < 3; s++) begin
        wait_play();
        frame(0, 0, 1, s);
      end
      frame(0, 0, 0, 0);
    end
    wait_play();
    check("sat_level", bus.level, 15);
    check("sat_score", bus.score, 9999);
    check("sat_speed", bus.speed_scale, 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frogger_game_ctrl.md
# frogger_game_ctrl

Game-level sequencer that sits above the frog, car and lily-pad datapaths. It owns lives, level, score and home-slot occupancy, and consumes the frog's death and win events. It issues the frog respawn pulse and a lane speed scale that the lane generators use for difficulty. It runs once per frame on the frame clock.

## Interface
Parameters:
- LIVES_INIT, 3: lives loaded at game start (1..3).
- RESPAWN_FRAMES, 30: frames spent in RESPAWN before PLAY.
- GAMEOVER_FRAMES, 120: frames shown in GAMEOVER before ATTRACT.
- SCORE_HOME, 50: points per newly filled home slot.
- SCORE_LEVEL, 200: points per cleared level.
- SCORE_MAX, 9999: score saturation value.
- TIME_INIT, 30: round timer reload, in ticks (ROUND_TIMER_EN only).
- TICK_FRAMES, 60: frames per timer tick (ROUND_TIMER_EN only).

Ports:
- frame_clk  in  1  frame clock; all state advances on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  start button, level-sensitive.
- frog_dead  in  1  frog death event (car, water or edge); one frame wide.
- frog_win  in  1  frog reached the home row; one frame wide.
- home_slot  in  2  home slot index valid with frog_win (0 = x120, 1 = x280, 2 = x400, 3 = invalid).
- frog_reset  out  1  respawn request to the frog; one-frame pulse.
- game_state  out  3  0 ATTRACT, 1 RESPAWN, 2 PLAY, 3 LEVELUP, 4 GAMEOVER.
- lives  out  2  remaining lives.
- level  out  4  current level, 1..15.
- score  out  14  unsigned binary score, 0..SCORE_MAX.
- home_filled  out  3  one bit per occupied home slot.
- speed_scale  out  3  min(level, 7); consumed by the lane generators.
- time_left  out  6  remaining round ticks.

## Operation
- Reset values: state ATTRACT, lives 0, level 1, score 0, home_filled 0, time_left 0, frog_reset 0, all counters 0.
- ATTRACT:
  - frog_dead and frog_win are ignored.
  - If start is 1: load lives = LIVES_INIT, level = 1, score = 0, home_filled = 0, then go to RESPAWN.
- RESPAWN:
  - Frame counter rcnt counts 0..RESPAWN_FRAMES-1, then the state goes to PLAY.
  - frog_reset = (state == RESPAWN && rcnt == 0). This is decoded from registers, so it is exactly one frame per entry.
  - frog_dead and frog_win are ignored.
- PLAY, with events evaluated in priority order:
  1. Loss: frog_dead, timeout, frog_win with home_slot == 3, or frog_win into a slot whose bit is already set.
     - lives decrements by 1.
     - If lives was 1, go to GAMEOVER (lives = 0); otherwise go to RESPAWN.
  2. Valid win:
     - Set home_filled[home_slot] and add SCORE_HOME to score.
     - If home_filled becomes 3'b111, go to LEVELUP; otherwise go to RESPAWN.
  3. Otherwise stay in PLAY.
- When frog_dead and frog_win are asserted in the same frame, death wins.
- LEVELUP, one frame:
  - Add SCORE_LEVEL to score.
  - level increments, saturating at 15.
  - home_filled clears to 0.
  - Go to RESPAWN.
- GAMEOVER:
  - Counter counts GAMEOVER_FRAMES frames, then the state goes to ATTRACT.
  - score and level are held until the next start.
  - start is ignored.
- Score arithmetic: computed in 15 bits, then score = min(sum, SCORE_MAX). No wrap.
- start held high across GAMEOVER → ATTRACT restarts the game on the first ATTRACT frame. This is intended.
- Reset asserted mid-game returns immediately to the reset values, with no respawn pulse.

## Timing
- All outputs except frog_reset are registered. frog_reset is a decode of registered state only, with no input-to-output path.
- Event latency: an event sampled at edge N changes the state at edge N. frog_reset is high during the frame after edge N.
- Dead-to-control latency: a PLAY death returns control to the frog after RESPAWN_FRAMES frames, i.e. PLAY resumes RESPAWN_FRAMES edges after entering RESPAWN.
- Lives, score and home_filled update on the same edge as the state transition that causes them.

## Configuration
- ROUND_TIMER_EN defined:
  - A 6-bit prescaler runs only in PLAY. Every TICK_FRAMES frames it decrements time_left.
  - time_left reloads TIME_INIT on every RESPAWN entry, and the prescaler clears there too.
  - When time_left == 0 in PLAY, the state counts as a timeout loss on the next edge.
- ROUND_TIMER_EN undefined:
  - The prescaler and timeout logic are absent.
  - time_left is tied to 0, and timeout never occurs.

## Test plan
- Reset, then start = 1 for 1 frame → RESPAWN; frog_reset high for exactly 1 frame; lives = 3, level = 1, score = 0; PLAY after 30 frames.
- In PLAY: frog_win at slots 0, 1, 2, each followed by respawn → score 50, 100, then 150 + 200 = 350; level = 2; home_filled = 0; speed_scale = 2.
- frog_win to an already-filled slot 1, and separately home_slot = 3 → treated as death; lives decrements; score is unchanged.
- Three frog_dead events with LIVES_INIT = 3 → lives 2, 1, then GAMEOVER with lives = 0; ATTRACT after 120 frames; score retained.
- Same-frame frog_dead and frog_win → death path only; home_filled is unchanged. Reset asserted mid-RESPAWN → ATTRACT immediately with all reset values.
- ROUND_TIMER_EN, TIME_INIT = 2, TICK_FRAMES = 4 → time_left 2 → 1 → 0 over 8 PLAY frames; timeout loss on the next edge; time_left reloads to 2 on RESPAWN entry.
